// File: rtl/johnson_pkg.sv
// Shared constants and ring helpers for the Johnson counter tile.
// Legality check and ring-to-step decode used by the correction logic.
package johnson_pkg;

  localparam int JW      = 8;
  localparam int JPERIOD = 2 * JW;

  function automatic logic is_legal(input logic [JW-1:0] ring);
    logic [JW-1:0] inv;
    inv = ~ring;
    // ones anchored at bit 0 (incl. 00), or zeros anchored at bit 0
    return ((ring & (ring + 1'b1)) == '0) ||
           ((inv & (inv + 1'b1)) == '0);
  endfunction

  function automatic logic [3:0] ring_to_step(input logic [JW-1:0] ring);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < JW; i++) begin
      n = n + {3'b000, ring[i] ^ ring[JW-1]};
    end
    return ring[JW-1] ? 4'd8 + n : n;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Self-correcting Johnson ring with a step index re-derived every edge.
// Illegal ring values restart the sequence from 00.
module johnson_core
  import johnson_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  output logic [JW-1:0] ring,
  output logic [3:0]    step,
  output logic          wrap
);

  logic          legal;
  logic [JW-1:0] ring_next;
  logic [3:0]    step_next;

  always_comb begin
    legal     = is_legal(ring);
    ring_next = '0;
    step_next = '0;
    if (legal) begin
      ring_next = {ring[JW-2:0], ~ring[JW-1]};
      step_next = ring_to_step(ring) + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring <= '0;
      step <= '0;
    end else begin
      ring <= ring_next;
      step <= step_next;
    end
  end

  assign wrap = (ring == 8'h80);

endmodule

// File: rtl/tt_um_johnson.sv
// TinyTapeout tile: Johnson ring on uo_out, step/wrap on uio_out.
// All bidirectional pins are driven as outputs at all times.
module tt_um_johnson
  import johnson_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [JW-1:0] ring;
  logic [3:0]    step;
  logic          wrap;

  johnson_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .ring  (ring),
    .step  (step),
    .wrap  (wrap)
  );

  assign uo_out  = ring;
  assign uio_out = {3'b000, wrap, step};
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_johnson.sv
// Directed bench for tt_um_johnson: reset, sequence, wrap,
// async reset, self-correction and junk-input immunity.
module tb_tt_um_johnson;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] SEQ [16] = '{
    8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
    8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
  };

  tt_um_johnson dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int p);
    check({tag, "_ring"}, uo_out, SEQ[p]);
    check({tag, "_step"}, {4'h0, uio_out[3:0]}, 8'(p));
    check({tag, "_wrap"}, {7'h0, uio_out[4]}, {7'h0, p == 15});
    check({tag, "_hi"}, {5'h0, uio_out[7:5]}, 8'h00);
    check({tag, "_oe"}, uio_oe, 8'hFF);
  endtask

  int pulses;
  int first_pulse;
  int last_pulse;
  int gap_bad;
  int guard;

  initial begin
    ena    = 1'bz;
    ui_in  = 'z;
    uio_in = 'z;

    // reset held with floating inputs
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_oe", uio_oe, 8'hFF);
    end

    // release between edges; two full periods
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check_pos("seq", k % 16);
    end

    // wrap pulses over 48 cycles, starting at position 0
    pulses = 0;
    first_pulse = -1;
    last_pulse = -1;
    gap_bad = 0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (uio_out[4] === 1'b1) begin
        pulses++;
        if (uo_out !== 8'h80) gap_bad++;
        if (last_pulse >= 0 && k - last_pulse != 16) gap_bad++;
        if (first_pulse < 0) first_pulse = k;
        last_pulse = k;
      end
    end
    check("wrap_count", 8'(pulses), 8'd3);
    check("wrap_gap", 8'(gap_bad), 8'd0);
    check("wrap_first", 8'(first_pulse), 8'd15);

    // async reset between edges at 3F
    guard = 0;
    while (uo_out !== 8'h3F && guard < 40) begin
      tick();
      guard++;
    end
    check("find_3f", uo_out, 8'h3F);
    #2 rst_n = 1'b0;
    #1;
    check("async_uo", uo_out, 8'h00);
    check("async_uio", uio_out, 8'h00);
    @(negedge clk);
    check("async_hold", uo_out, 8'h00);
    rst_n = 1'b1;
    tick();
    check_pos("post_rst", 1);

    // illegal ring value recovers to 00 then 01
    force dut.u_core.ring = 8'h55;
    #1 release dut.u_core.ring;
    #1;
    check("forced", uo_out, 8'h55);
    tick();
    check_pos("recover0", 0);
    tick();
    check_pos("recover1", 1);

    // step disagreeing with ring is re-derived
    tick();
    check_pos("pre_step", 2);
    force dut.u_core.step = 4'd9;
    #1 release dut.u_core.step;
    #1;
    check("forced_step", {4'h0, uio_out[3:0]}, 8'h09);
    tick();
    check_pos("step_fix", 3);

    // junk inputs: random, X and Z, sequence unchanged
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      case (k % 3)
        0: begin
          ui_in  = 8'($urandom);
          uio_in = 8'($urandom);
          ena    = 1'($urandom);
        end
        1: begin
          ui_in  = 'x;
          uio_in = 'x;
          ena    = 1'bx;
        end
        default: begin
          ui_in  = 'z;
          uio_in = 'z;
          ena    = 1'bz;
        end
      endcase
      tick();
      check_pos("junk", k % 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
